// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder now, subtractor later).
package serial_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder; sister cell of full_subtractor.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    logic half;

    assign half  = a ^ b;
    assign sum   = half ^ c;
    assign carry = (a & b) | (c & half);

endmodule

// File: rtl/serial_full_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock LSB first, start/done handshake.
module serial_full_adder
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] res_next;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Sum bits enter at the MSB so after WIDTH steps bit 0 sits at index 0.
    assign res_next = {fa_sum, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        res_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= res_next;
                    carry  <= fa_carry;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        sum   <= res_next;
                        cout  <= fa_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder at WIDTH=8 (directed + random) and WIDTH=4 (exhaustive).
module tb_serial_full_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    serial_full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_full_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    logic       use4 = 1'b0;
    logic       m_busy, m_done, m_cout;
    logic [8:0] m_res;
    assign m_busy = use4 ? busy4 : busy8;
    assign m_done = use4 ? done4 : done8;
    assign m_cout = use4 ? cout4 : cout8;
    assign m_res  = use4 ? {4'b0, cout4, sum4} : {cout8, sum8};

    logic [8:0] prev_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c);
        if (use4) begin
            a4 = a[3:0]; b4 = b[3:0]; cin4 = c; start4 = 1'b1;
        end else begin
            a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        end
        tick();
        start4 = 1'b0;
        start8 = 1'b0;
        // Scramble the live inputs: only the captured copies may matter.
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, input logic [8:0] expv, input int inject_at,
                             output int lat);
        int n = 0;
        int busy_cnt = 0;
        int w = use4 ? 4 : 8;
        logic held = 1'b1;
        while (!m_done && n < 30) begin
            if (m_busy) busy_cnt++;
            if (m_res !== prev_res) held = 1'b0;
            if (n == inject_at) begin
                start8 = 1'b1; a8 = 8'h55; b8 = 8'h55; cin8 = 1'b0;
            end else begin
                start8 = 1'b0;
            end
            tick();
            n++;
        end
        start8 = 1'b0;
        lat = n;
        check({tag, "_latency"}, n, w);
        check({tag, "_busy_cycles"}, busy_cnt, w);
        check({tag, "_held"}, {31'b0, held}, 1);
        check({tag, "_busy_at_done"}, {31'b0, m_busy}, 0);
        check({tag, "_result"}, {23'b0, m_res}, {23'b0, expv});
        prev_res = expv;
    endtask

    task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input int inject_at, output int lat);
        logic [8:0] expv;
        if (use4) expv = 9'(a[3:0]) + 9'(b[3:0]) + 9'(c);
        else      expv = 9'(a) + 9'(b) + 9'(c);
        launch(a, b, c);
        wait_done(tag, expv, inject_at, lat);
    endtask

    initial begin
        int lat;
        int extra;
        logic [7:0] ra, rb;
        logic rc;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        prev_res = '0;
        #12;
        check("reset8_outputs", {22'b0, busy8, done8, cout8, sum8}, 0);
        check("reset4_outputs", {26'b0, busy4, done4, cout4, sum4}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        op("basic", 8'h0F, 8'h01, 1'b0, -1, lat);
        tick();
        check("done_one_cycle", {31'b0, done8}, 0);

        op("wrap_ff_01", 8'hFF, 8'h01, 1'b0, -1, lat);
        op("wrap_ff_ff_c", 8'hFF, 8'hFF, 1'b1, -1, lat);
        check("b2b_gap", lat + 1, 9);
        op("b2b_second", 8'h3C, 8'hA7, 1'b0, -1, lat);
        check("b2b_gap2", lat + 1, 9);
        tick();

        op("ignore_busy", 8'h12, 8'h34, 1'b0, 2, lat);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) extra++;
        end
        check("ignore_no_second_done", extra, 0);

        launch(8'hA5, 8'h3C, 1'b1);
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs", {22'b0, busy8, done8, cout8, sum8}, 0);
        prev_res = '0;
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8 || sum8 != 8'h00) extra++;
        end
        check("midrst_quiet", extra, 0);
        op("after_rst", 8'hA5, 8'h3C, 1'b1, -1, lat);
        tick();

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            if ($urandom_range(0, 1) == 1) tick();
            op("random8", ra, rb, rc, -1, lat);
        end
        tick();

        use4 = 1'b1;
        prev_res = '0;
        for (int unsigned ea = 0; ea < 16; ea++)
            for (int unsigned eb = 0; eb < 16; eb++)
                for (int unsigned ec = 0; ec < 2; ec++)
                    op("exh4", 8'(ea), 8'(eb), 1'(ec), -1, lat);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
